// File: rtl/adc_frame_pkg.sv
// Shared constants and types for the ADC result-frame receiver.
package adc_frame_pkg;

  localparam int unsigned FRAME_BYTES = 6;
  localparam int unsigned FRAME_W     = FRAME_BYTES * 8;

  localparam int unsigned RUNUP_MSB = 46;
  localparam int unsigned RUNUP_LSB = 32;
  localparam int unsigned SIGN_BIT  = 31;
  localparam int unsigned SET_MSB   = 30;
  localparam int unsigned SET_LSB   = 16;
  localparam int unsigned RDN_MSB   = 15;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_STOP    = 2'd1,
    ERR_SYNC    = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_rx_os.sv
// 8N1 UART receiver: 2-FF synchroniser, mid-bit sampling FSM, byte/stop-error pulses.
module uart_rx_os
  import adc_frame_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 640
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_in,
  output logic [7:0] rx_byte,
  output logic       byte_done,
  output logic       stop_err,
  output logic       rx_idle
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_e        state_q, state_d;
  logic [2:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             rearm_q, rearm_d;
  logic             line, fall, tick;

  // sync_q[1] is the synchronised line; sync_q[2] is its previous value for edge detect.
  assign line = sync_q[1];
  assign fall = sync_q[2] & ~sync_q[1];
  assign tick = (cnt_q == FULL_M1);

  always_comb begin
    sync_d    = {sync_q[1:0], rx_in};
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    rearm_d   = rearm_q;
    byte_done = 1'b0;
    stop_err  = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        // After a framing error, wait for a full bit-time of idle high before re-arming.
        if (rearm_q) begin
          if (!line) begin
            cnt_d = '0;
          end else if (tick) begin
            cnt_d   = '0;
            rearm_d = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (fall) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = line ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (tick) begin
          cnt_d   = '0;
          shift_d = {line, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (tick) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (line) begin
            byte_done = 1'b1;
          end else begin
            stop_err = 1'b1;
            rearm_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RX_IDLE;
      sync_q  <= '1;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      rearm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      rearm_q <= rearm_d;
    end
  end

  assign rx_byte = shift_q;
  assign rx_idle = (state_q == RX_IDLE);

endmodule

// File: rtl/adc_frame_rx.sv
// Multislope ADC result-frame receiver: byte assembly, inter-byte timeout and field decode.
module adc_frame_rx
  import adc_frame_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 640,
  parameter int unsigned GAP_BITS     = 24
) (
  input  logic        mclk,
  input  logic        rst_n,
  input  logic        si_dat,
  output logic        frame_valid,
  output logic [14:0] runup_cnt,
  output logic        rundown_sign,
  output logic [14:0] runup_set,
  output logic [15:0] rundown_cnt,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic [15:0] frame_count
);

  localparam int unsigned IDX_W   = $clog2(FRAME_BYTES);
  localparam int unsigned GAP_CYC = GAP_BITS * CLKS_PER_BIT;
  localparam int unsigned GAP_W   = $clog2(GAP_CYC);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);
  localparam logic [GAP_W-1:0] GAP_M1   = GAP_W'(GAP_CYC - 1);

  logic [7:0] rx_byte;
  logic       byte_done, stop_err, rx_idle;

  uart_rx_os #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk      (mclk),
    .rst_n    (rst_n),
    .rx_in    (si_dat),
    .rx_byte  (rx_byte),
    .byte_done(byte_done),
    .stop_err (stop_err),
    .rx_idle  (rx_idle)
  );

  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [FRAME_W-1:0] word_q, word_d, word_next;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [14:0]        runup_q, runup_d, set_q, set_d;
  logic               sign_q, sign_d;
  logic [15:0]        rdn_q, rdn_d, fcount_q, fcount_d;
  logic               valid_q, valid_d, err_q, err_d;
  err_code_e          code_q, code_d;
  logic               timeout;

  assign word_next = {word_q[FRAME_W-9:0], rx_byte};
  // The gap timer only runs while a partial frame is pending and the receiver is idle.
  assign timeout   = rx_idle && (idx_q != '0) && (gap_q == GAP_M1);

  always_comb begin
    idx_d    = idx_q;
    word_d   = word_q;
    gap_d    = (!rx_idle || idx_q == '0) ? '0 : gap_q + GAP_W'(1);
    runup_d  = runup_q;
    sign_d   = sign_q;
    set_d    = set_q;
    rdn_d    = rdn_q;
    fcount_d = fcount_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    code_d   = ERR_NONE;
    if (stop_err) begin
      err_d  = 1'b1;
      code_d = ERR_STOP;
      idx_d  = '0;
      word_d = '0;
    end else if (timeout) begin
      err_d  = 1'b1;
      code_d = ERR_TIMEOUT;
      idx_d  = '0;
      word_d = '0;
    end else if (byte_done) begin
      if (idx_q == '0 && rx_byte[7]) begin
        err_d  = 1'b1;
        code_d = ERR_SYNC;
        word_d = '0;
      end else if (idx_q == LAST_IDX) begin
        valid_d  = 1'b1;
        fcount_d = fcount_q + 16'd1;
        runup_d  = word_next[RUNUP_MSB:RUNUP_LSB];
        sign_d   = word_next[SIGN_BIT];
        set_d    = word_next[SET_MSB:SET_LSB];
        rdn_d    = word_next[RDN_MSB:0];
        idx_d    = '0;
        word_d   = '0;
      end else begin
        word_d = word_next;
        idx_d  = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      idx_q    <= '0;
      word_q   <= '0;
      gap_q    <= '0;
      runup_q  <= '0;
      sign_q   <= 1'b0;
      set_q    <= '0;
      rdn_q    <= '0;
      fcount_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= ERR_NONE;
    end else begin
      idx_q    <= idx_d;
      word_q   <= word_d;
      gap_q    <= gap_d;
      runup_q  <= runup_d;
      sign_q   <= sign_d;
      set_q    <= set_d;
      rdn_q    <= rdn_d;
      fcount_q <= fcount_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      code_q   <= code_d;
    end
  end

  assign frame_valid  = valid_q;
  assign runup_cnt    = runup_q;
  assign rundown_sign = sign_q;
  assign runup_set    = set_q;
  assign rundown_cnt  = rdn_q;
  assign frame_err    = err_q;
  assign err_code     = code_q;
  assign frame_count  = fcount_q;

endmodule

// File: tb/tb_adc_frame_rx.sv
// Directed bench for adc_frame_rx at 16 clocks per bit.
module tb_adc_frame_rx;

  localparam int unsigned CPB = 16;
  localparam logic [47:0] FRAME_A = 48'h03E8_87CF_1234;
  localparam logic [47:0] FRAME_B = 48'h00C7_00C7_FFFF;

  logic        mclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        si_dat = 1'b1;
  logic        frame_valid, rundown_sign, frame_err;
  logic [14:0] runup_cnt, runup_set;
  logic [15:0] rundown_cnt, frame_count;
  logic [1:0]  err_code;

  int errors = 0;
  int checks = 0;

  adc_frame_rx #(.CLKS_PER_BIT(CPB), .GAP_BITS(24)) dut (
    .mclk        (mclk),
    .rst_n       (rst_n),
    .si_dat      (si_dat),
    .frame_valid (frame_valid),
    .runup_cnt   (runup_cnt),
    .rundown_sign(rundown_sign),
    .runup_set   (runup_set),
    .rundown_cnt (rundown_cnt),
    .frame_err   (frame_err),
    .err_code    (err_code),
    .frame_count (frame_count)
  );

  always #5 mclk = ~mclk;

  // Pulse monitor: records every valid/error pulse with the values seen in that cycle.
  int          vcnt = 0;
  int          ecnt = 0;
  int          both = 0;
  logic [1:0]  last_code = 2'd0;
  logic [14:0] cap_runup [16];
  logic        cap_sign  [16];
  logic [14:0] cap_set   [16];
  logic [15:0] cap_rdn   [16];
  logic [15:0] cap_fc    [16];

  always @(posedge mclk) begin
    #1;
    if (frame_valid && vcnt < 16) begin
      cap_runup[vcnt] = runup_cnt;
      cap_sign[vcnt]  = rundown_sign;
      cap_set[vcnt]   = runup_set;
      cap_rdn[vcnt]   = rundown_cnt;
      cap_fc[vcnt]    = frame_count;
    end
    if (frame_valid) vcnt++;
    if (frame_err) begin
      ecnt++;
      last_code = err_code;
    end
    if (frame_valid && frame_err) both++;
  end

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_bits(input int n);
    si_dat = 1'b1;
    repeat (n * CPB) @(negedge mclk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_hi);
    si_dat = 1'b0;
    repeat (CPB) @(negedge mclk);
    for (int i = 0; i < 8; i++) begin
      si_dat = b[i];
      repeat (CPB) @(negedge mclk);
    end
    si_dat = stop_hi;
    repeat (CPB) @(negedge mclk);
    si_dat = 1'b1;
  endtask

  task automatic send_frame(input logic [47:0] w);
    for (int i = 5; i >= 0; i--) send_byte(w[i*8 +: 8], 1'b1);
  endtask

  task automatic chk_cap(input string tag, input int k, input logic [47:0] w, input logic [15:0] fc);
    chk({tag, "_runup"}, 80'(cap_runup[k]), 80'(w[46:32]));
    chk({tag, "_sign"},  80'(cap_sign[k]),  80'(w[31]));
    chk({tag, "_set"},   80'(cap_set[k]),   80'(w[30:16]));
    chk({tag, "_rdn"},   80'(cap_rdn[k]),   80'(w[15:0]));
    chk({tag, "_fc"},    80'(cap_fc[k]),    80'(fc));
  endtask

  function automatic logic [79:0] all_outs();
    return 80'({frame_valid, runup_cnt, rundown_sign, runup_set, rundown_cnt,
                frame_err, err_code, frame_count});
  endfunction

  initial begin
    repeat (4) @(negedge mclk);
    chk("reset_outs", all_outs(), '0);
    rst_n = 1'b1;
    idle_bits(2);

    // Single frame: 1000 / + / 1999 / 0x1234
    send_frame(FRAME_A);
    idle_bits(1);
    chk("a_vcnt", 80'(vcnt), 80'(1));
    chk("a_runup_val", 80'(runup_cnt), 80'(1000));
    chk("a_set_val", 80'(runup_set), 80'(1999));
    chk_cap("a", 0, FRAME_A, 16'd1);

    // Reset clears everything, then two frames back to back.
    rst_n = 1'b0;
    repeat (3) @(negedge mclk);
    chk("rst2_outs", all_outs(), '0);
    rst_n = 1'b1;
    idle_bits(2);
    send_frame(FRAME_A);
    send_frame(FRAME_B);
    idle_bits(1);
    chk("b2b_vcnt", 80'(vcnt), 80'(3));
    chk_cap("b2b0", 1, FRAME_A, 16'd1);
    chk_cap("b2b1", 2, FRAME_B, 16'd2);

    // Partial frame then a long gap: timeout, fields hold.
    send_byte(8'h03, 1'b1);
    send_byte(8'hE8, 1'b1);
    send_byte(8'h87, 1'b1);
    idle_bits(30);
    chk("to_ecnt", 80'(ecnt), 80'(1));
    chk("to_code", 80'(last_code), 80'(3));
    chk("to_hold", 80'({runup_cnt, rundown_sign, runup_set, rundown_cnt}),
        80'({15'd199, 1'b0, 15'd199, 16'hFFFF}));
    chk("to_vcnt", 80'(vcnt), 80'(3));
    send_frame(FRAME_A);
    idle_bits(1);
    chk("to_next_vcnt", 80'(vcnt), 80'(4));
    chk_cap("to_next", 3, FRAME_A, 16'd3);

    // Low stop bit on the third byte.
    send_byte(8'h03, 1'b1);
    send_byte(8'hE8, 1'b1);
    send_byte(8'h87, 1'b0);
    idle_bits(2);
    chk("stop_ecnt", 80'(ecnt), 80'(2));
    chk("stop_code", 80'(last_code), 80'(1));
    chk("stop_hold", 80'({runup_cnt, rundown_sign, runup_set, rundown_cnt, frame_count}),
        80'({15'd1000, 1'b1, 15'd1999, 16'h1234, 16'd3}));
    send_frame(FRAME_B);
    idle_bits(1);
    chk("stop_next_vcnt", 80'(vcnt), 80'(5));
    chk_cap("stop_next", 4, FRAME_B, 16'd4);

    // First byte with bit7 set is a sync error.
    send_byte(8'h80, 1'b1);
    idle_bits(1);
    chk("sync_ecnt", 80'(ecnt), 80'(3));
    chk("sync_code", 80'(last_code), 80'(2));
    chk("sync_vcnt", 80'(vcnt), 80'(5));
    send_frame(FRAME_A);
    idle_bits(1);
    chk("sync_next_vcnt", 80'(vcnt), 80'(6));
    chk_cap("sync_next", 5, FRAME_A, 16'd5);

    // Short low glitch on an idle line is ignored.
    si_dat = 1'b0;
    repeat (3) @(negedge mclk);
    si_dat = 1'b1;
    idle_bits(3);
    chk("glitch_ecnt", 80'(ecnt), 80'(3));
    chk("glitch_vcnt", 80'(vcnt), 80'(6));

    // Reset mid-frame: no error pulse, counter restarts.
    send_byte(8'h03, 1'b1);
    send_byte(8'hE8, 1'b1);
    send_byte(8'h87, 1'b1);
    si_dat = 1'b0;
    repeat (40) @(negedge mclk);
    rst_n = 1'b0;
    repeat (3) @(negedge mclk);
    chk("rst3_outs", all_outs(), '0);
    si_dat = 1'b1;
    repeat (2) @(negedge mclk);
    rst_n = 1'b1;
    idle_bits(2);
    chk("rst3_ecnt", 80'(ecnt), 80'(3));
    send_frame(FRAME_B);
    idle_bits(1);
    chk("rst3_vcnt", 80'(vcnt), 80'(7));
    chk_cap("rst3_next", 6, FRAME_B, 16'd1);

    chk("no_overlap", 80'(both), 80'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
